// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants and write-back select encoding.
// Imported by the write-back stage and the control decoder.
package wb_regfile_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/wb_regfile_2r1w.sv
// Two-read one-write register file with x0 masking
// and write-first bypass on both read ports.
module regfile_2r1w #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);
  import wb_regfile_pkg::*;

  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_ok;

  assign wr_ok = we && (waddr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[waddr] <= wdata;
    end
  end

  // x0 reads as zero; a same-cycle write wins over the array
  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    if (wr_ok && raddr_a == waddr)
      rdata_a = wdata;
    if (wr_ok && raddr_b == waddr)
      rdata_b = wdata;
    if (raddr_a == REG_ZERO)
      rdata_a = '0;
    if (raddr_b == REG_ZERO)
      rdata_b = '0;
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, write qualification,
// architectural register file, last-write and perf counters.
module wb_regfile #(
  parameter int XLEN = wb_regfile_pkg::XLEN,
  parameter int NREG = wb_regfile_pkg::NREG,
  parameter int AW   = wb_regfile_pkg::AW,
  parameter int CW   = wb_regfile_pkg::CW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            RegWrite_store,
  input  logic            MemtoReg_store,
  input  logic [XLEN-1:0] ReadData_store,
  input  logic [XLEN-1:0] ALU_result_store,
  input  logic [AW-1:0]   rd_store,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic [AW-1:0]   last_rd,
  output logic [XLEN-1:0] last_data,
  output logic [CW-1:0]   retire_count,
  output logic [CW-1:0]   commit_count
);
  import wb_regfile_pkg::*;

  wb_sel_e         sel;
  logic [AW-1:0]   last_rd_q, last_rd_d;
  logic [XLEN-1:0] last_data_q, last_data_d;
  logic [CW-1:0]   retire_q, retire_d;
  logic [CW-1:0]   commit_q, commit_d;

  assign sel     = wb_sel_e'(MemtoReg_store);
  assign wb_data = (sel == WB_SEL_MEM) ? ReadData_store
                                       : ALU_result_store;
  // wb_valid=0 forces 0 even when the other fields are X
  assign wb_we   = wb_valid & RegWrite_store
                 & (rd_store != REG_ZERO) & ~reset;

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (rd_store),
    .wdata   (wb_data),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .rdata_a (rd1),
    .rdata_b (rd2)
  );

  always_comb begin
    last_rd_d   = last_rd_q;
    last_data_d = last_data_q;
    retire_d    = retire_q;
    commit_d    = commit_q;
    if (wb_we) begin
      last_rd_d   = rd_store;
      last_data_d = wb_data;
      commit_d    = commit_q + CW'(1);
    end
    if (wb_valid)
      retire_d = retire_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_rd_q   <= '0;
      last_data_q <= '0;
      retire_q    <= '0;
      commit_q    <= '0;
    end else begin
      last_rd_q   <= last_rd_d;
      last_data_q <= last_data_d;
      retire_q    <= retire_d;
      commit_q    <= commit_d;
    end
  end

  assign last_rd      = last_rd_q;
  assign last_data    = last_data_q;
  assign retire_count = retire_q;
  assign commit_count = commit_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile against an
// array-based reference model of the write-back rules.
module tb_wb_regfile;
  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int CW   = 8;

  logic            clk;
  logic            reset;
  logic            wb_valid;
  logic            RegWrite_store;
  logic            MemtoReg_store;
  logic [XLEN-1:0] ReadData_store;
  logic [XLEN-1:0] ALU_result_store;
  logic [AW-1:0]   rd_store;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;
  logic [AW-1:0]   last_rd;
  logic [XLEN-1:0] last_data;
  logic [CW-1:0]   retire_count;
  logic [CW-1:0]   commit_count;

  wb_regfile #(.XLEN(XLEN), .NREG(32), .AW(AW), .CW(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_valid         (wb_valid),
    .RegWrite_store   (RegWrite_store),
    .MemtoReg_store   (MemtoReg_store),
    .ReadData_store   (ReadData_store),
    .ALU_result_store (ALU_result_store),
    .rd_store         (rd_store),
    .rs1              (rs1),
    .rs2              (rs2),
    .rd1              (rd1),
    .rd2              (rd2),
    .wb_data          (wb_data),
    .wb_we            (wb_we),
    .last_rd          (last_rd),
    .last_data        (last_data),
    .retire_count     (retire_count),
    .commit_count     (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              chk;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] wbd;
    logic            we;
  } comb_t;

  typedef struct {
    logic [AW-1:0]   lrd;
    logic [XLEN-1:0] ld;
    logic [CW-1:0]   ret;
    logic [CW-1:0]   com;
  } reg_t;

  comb_t qc[$];
  reg_t  qr[$];

  logic [XLEN-1:0] m_regs [32];
  int unsigned     m_ret, m_com;
  logic [AW-1:0]   m_lrd;
  logic [XLEN-1:0] m_ld;

  int  total = 0;
  int  bad   = 0;
  bit  done  = 0;

  task automatic cmp(string name, logic [XLEN-1:0] got,
                     logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] m_read(
      logic [AW-1:0] a, bit we, logic [AW-1:0] wa,
      logic [XLEN-1:0] wd);
    if (a == 0) return '0;
    if (we && a == wa) return wd;
    return m_regs[a];
  endfunction

  // Drive one cycle at the falling edge and queue expectations
  task automatic step(bit r, bit v, bit rw, bit m2r,
                      logic [XLEN-1:0] rdat, logic [XLEN-1:0] alu,
                      logic [AW-1:0] rd, logic [AW-1:0] a,
                      logic [AW-1:0] b, bit chk);
    comb_t c;
    reg_t  g;
    bit    we;
    logic [XLEN-1:0] d;
    @(negedge clk);
    reset = r; wb_valid = v; RegWrite_store = rw;
    MemtoReg_store = m2r; ReadData_store = rdat;
    ALU_result_store = alu; rd_store = rd; rs1 = a; rs2 = b;
    d  = m2r ? rdat : alu;
    we = !r && v && rw && rd != 0;
    c.chk = chk;
    c.rd1 = m_read(a, we, rd, d);
    c.rd2 = m_read(b, we, rd, d);
    c.wbd = d;
    c.we  = we;
    qc.push_back(c);
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_ret = 0; m_com = 0; m_lrd = 0; m_ld = 0;
    end else begin
      if (v) m_ret = (m_ret + 1) % (1 << CW);
      if (we) begin
        m_regs[rd] = d;
        m_lrd = rd; m_ld = d;
        m_com = (m_com + 1) % (1 << CW);
      end
    end
    g.lrd = m_lrd; g.ld = m_ld;
    g.ret = CW'(m_ret); g.com = CW'(m_com);
    qr.push_back(g);
  endtask

  task automatic rnd_step(bit allow_reset);
    bit r;
    r = allow_reset && ($urandom_range(0, 99) == 0);
    step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
         1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
         AW'($urandom), AW'($urandom), AW'($urandom), 1);
  endtask

  // Monitor: combinational outputs before the edge, registered after
  initial begin
    comb_t c;
    reg_t  g;
    while (!done) begin
      @(negedge clk);
      #2;
      if (qc.size() > 0) begin
        c = qc.pop_front();
        if (c.chk) begin
          cmp("rd1", rd1, c.rd1);
          cmp("rd2", rd2, c.rd2);
          cmp("wb_data", wb_data, c.wbd);
          cmp("wb_we", XLEN'(wb_we), XLEN'(c.we));
        end
      end
      @(posedge clk);
      #1;
      if (qr.size() > 0) begin
        g = qr.pop_front();
        cmp("last_rd", XLEN'(last_rd), XLEN'(g.lrd));
        cmp("last_data", last_data, g.ld);
        cmp("retire_count", XLEN'(retire_count), XLEN'(g.ret));
        cmp("commit_count", XLEN'(commit_count), XLEN'(g.com));
      end
    end
  end

  initial begin
    reset = 1; wb_valid = 0; RegWrite_store = 0; MemtoReg_store = 0;
    ReadData_store = '0; ALU_result_store = '0;
    rd_store = '0; rs1 = '0; rs2 = '0;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_ret = 0; m_com = 0; m_lrd = 0; m_ld = 0;

    step(1, 0, 0, 0, 0, 0, 0, 5, 31, 0);
    step(1, 1, 1, 0, 0, 64'h77, 4, 5, 31, 1);
    step(0, 0, 0, 0, 0, 0, 0, 5, 31, 1);
    // ALU write with same-cycle bypass, then array read
    step(0, 1, 1, 0, 64'h0, 64'hDEAD_BEEF_0000_0001, 7, 7, 7, 1);
    step(0, 0, 0, 0, 0, 0, 0, 7, 0, 1);
    // load-data write
    step(0, 1, 1, 1, 64'h1234, 64'h9999, 3, 3, 7, 1);
    step(0, 0, 0, 0, 0, 0, 0, 3, 3, 1);
    // x0 write dropped, still retires
    step(0, 1, 1, 0, 0, 64'hFFFF, 0, 0, 3, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 1);
    // bubble with RegWrite set
    step(0, 0, 1, 0, 0, 64'h55, 9, 9, 9, 1);
    step(0, 0, 0, 0, 0, 0, 0, 9, 3, 1);
    // bubble with unknown payload
    step(0, 0, 1'bx, 1'bx, 'x, 'x, 'x, 3, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 3, 7, 1);
    // reset concurrent with a valid write
    step(1, 1, 1, 0, 0, 64'hAA, 4, 4, 3, 1);
    step(0, 0, 0, 0, 0, 0, 0, 4, 3, 1);

    for (int i = 0; i < 400; i++) rnd_step(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // back-to-back retires past 2^CW to force a wrap
    for (int i = 0; i < (1 << CW) + 3; i++)
      step(0, 1, 0, 0, 0, 0, 0, AW'(i), AW'(i + 1), 1);
    for (int i = 0; i < 300; i++) rnd_step(0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    done = 1;
    #2;
    total++;
    if (qc.size() != 0 || qr.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", qc.size() + qr.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file for the 64-bit five-stage pipeline.
- Consumes the stored MEM/WB pipeline-register outputs, selects the write-back value, and commits it to a 32-entry register file.
- Serves the two decode-stage read ports with same-cycle write bypass.
- Keeps retire and commit counters for the debug/perf path.

Parameters:
- XLEN, 64, datapath and register width
- NREG, 32, number of architectural registers (x0..x31)
- AW, 5, register index width (log2 NREG)
- CW, 32, width of the retire/commit counters

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  MEM/WB slot holds a real instruction (0 = bubble)
- RegWrite_store  in  1  stored register-write enable from MEM/WB
- MemtoReg_store  in  1  1 = write load data, 0 = write ALU result
- ReadData_store  in  XLEN  stored load data
- ALU_result_store  in  XLEN  stored ALU result
- rd_store  in  AW  stored destination index
- rs1  in  AW  decode read index A
- rs2  in  AW  decode read index B
- rd1  out  XLEN  read data A (combinational)
- rd2  out  XLEN  read data B (combinational)
- wb_data  out  XLEN  selected write-back value (combinational)
- wb_we  out  1  effective write enable this cycle (combinational)
- last_rd  out  AW  index of the most recent committed write (registered)
- last_data  out  XLEN  data of the most recent committed write (registered)
- retire_count  out  CW  valid instructions retired
- commit_count  out  CW  register writes committed

Behaviour:
- wb_data = MemtoReg_store ? ReadData_store : ALU_result_store. It follows its inputs even when wb_we = 0.
- wb_we = wb_valid & RegWrite_store & (rd_store != 0) & ~reset.
- Rising edge with reset=1:
  - All NREG entries clear to 0.
  - last_rd = 0, last_data = 0, retire_count = 0, commit_count = 0.
  - Any write presented in that cycle is dropped.
- Rising edge with reset=0 and wb_we=1:
  - regs[rd_store] <= wb_data.
  - last_rd <= rd_store, last_data <= wb_data.
  - commit_count += 1.
- Rising edge with reset=0 and wb_valid=1: retire_count += 1, whether or not the instruction writes a register.
- Bubbles (wb_valid=0) change no state, even if RegWrite_store=1.
- x0 handling:
  - Writes to x0 are ignored; commit_count does not increment for them; last_rd/last_data are unchanged.
  - rd1/rd2 for index 0 always return 0.
- Read path (per port, same for rs2/rd2):
  - rs1 == 0 -> 0.
  - else if wb_we && rs1 == rd_store -> wb_data (write-first bypass, same cycle).
  - else -> regs[rs1].
- Both ports may address the same register, or the write target, in the same cycle; both then return the bypassed value.
- Latency:
  - Committed data is visible on rd1/rd2 in the same cycle through the bypass, and from the array from the next cycle on.
  - last_* and the counters update one cycle after the qualifying input.
- Counters wrap modulo 2^CW with no saturation. They hold their value with no event.
- Reset is the only clear mechanism; the array is never cleared implicitly.
- X-safety: when wb_valid=0, the X state of the other MEM/WB inputs must not corrupt any state.

Decomposition:
- Shared pipeline package holds:
  - XLEN, NREG, AW constants.
  - Index constant REG_ZERO = 0.
  - Write-back select encoding (WB_SEL_ALU = 0, WB_SEL_MEM = 1), shared with the control decoder.
- One natural sub-module: regfile_2r1w. It contains the array, reset clear, x0 masking and write-first bypass.
- wb_regfile wraps regfile_2r1w with the write-back mux, enable qualification, last_* registers and counters.

Test Plan:
- Reset, then rs1=5 and rs2=31 -> rd1=rd2=0, both counters 0, last_rd=0.
- Valid write, MemtoReg=0, ALU_result=64'hDEAD_BEEF_0000_0001, rd=7, with rs1=7 in the same cycle:
  - Same cycle: rd1 bypasses 64'hDEAD_BEEF_0000_0001.
  - Next cycle: it reads from the array; commit_count=1, retire_count=1, last_rd=7.
- Valid write, MemtoReg=1, ReadData=64'h1234, ALU_result=64'h9999, rd=3 -> regs[3]=64'h1234, and wb_data=64'h1234 during the write cycle.
- Write to rd=0 with data 64'hFFFF -> rd1(rs1=0)=0, commit_count unchanged, retire_count +1, last_* unchanged.
- Bubble: wb_valid=0, RegWrite=1, rd=9, data=64'h55 -> regs[9] unchanged, counters unchanged.
- Reset asserted in the same cycle as a valid write to rd=4 with 64'hAA -> regs[4]=0 and all counters 0 after the edge.
- Counter wrap: preload via 2^CW valid retires, or CW=4 with 16 retires -> retire_count returns to 0.
